// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
//
// Drives the enable/flush controls of the PC, IF/ID, ID/EX and EX/MEM
// registers. Hazard priority: data-memory wait > control redirect > load-use.
// States: RUN (00), WAIT_MEM (01, multi-cycle data access with optional
// timeout), REDIRECT (10, extra IF/ID bubbles after a taken branch/jump).
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   defined   -> perf_stall_cycles / perf_flushes counters are built
//   undefined -> no counter flops, both outputs tied to 0
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   id_rs1/id_rs2       source registers of the ID instruction
//   id_uses_rs1/2       ID instruction actually reads rs1/rs2
//   ex_memRead, ex_rd   EX instruction is a load / its destination
//   ex_redirect         taken branch or jump resolved in EX
//   mem_req, mem_ready  MEM-stage access pending / completing
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en
//                       pipeline register controls (flush overrides enable)
//   mem_timeout         one-cycle pulse on forced WAIT_MEM release
//   ctrl_state          current FSM state
//   perf_stall_cycles   load-use + memory stall cycles
//   perf_flushes        redirect events
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT      = 16,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flushes
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_WAIT  = 2'b01,
        S_REDIR = 2'b10
    } state_t;

    localparam int            WC      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC-1:0] TO_LAST = WC'(MEM_TIMEOUT - 1);
    localparam logic [2:0]    RB      = 3'(REDIRECT_BUBBLES);

    state_t        r_state;
    state_t        r_saved;     // state to resume after WAIT_MEM
    logic [2:0]    r_rcnt;      // remaining REDIRECT cycles; frozen during WAIT_MEM
    logic [WC-1:0] r_wait_cnt;

    logic w_req_stall;
    logic w_hit_to;
    logic w_timeout;
    logic w_mem_stall;
    logic w_redirect;
    logic w_load_use;

    always_comb begin
        w_req_stall = mem_req && !mem_ready;
        w_hit_to    = (MEM_TIMEOUT != 0) && (r_state == S_WAIT) && (r_wait_cnt == TO_LAST);
        w_timeout   = w_hit_to && w_req_stall;
        // A timed-out access counts as completed, so it no longer stalls.
        w_mem_stall = w_req_stall && !w_hit_to;
        // Redirects are only acted on in RUN/REDIRECT; a WAIT_MEM release cycle
        // just restores the saved state.
        w_redirect  = ex_redirect && !w_mem_stall && (r_state != S_WAIT);
        w_load_use  = (r_state == S_RUN) && !w_mem_stall && !ex_redirect &&
                      ex_memRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_timeout = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (r_state == S_WAIT) begin
            mem_timeout = w_timeout;
        end else if (w_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (r_state == S_REDIR) begin
            if_id_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign ctrl_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_saved    <= S_RUN;
            r_rcnt     <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_mem_stall)
                        r_wait_cnt <= r_wait_cnt + WC'(1);
                    else
                        r_state <= r_saved;
                end
                default: begin
                    if (w_mem_stall) begin
                        r_saved    <= r_state;
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end else if (ex_redirect) begin
                        if (RB != 3'd0) begin
                            r_state <= S_REDIR;
                            r_rcnt  <= RB;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else if (r_state == S_REDIR) begin
                        if (r_rcnt == 3'd1)
                            r_state <= S_RUN;
                        r_rcnt <= r_rcnt - 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_mem_stall || w_load_use)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_redirect)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cycles = r_stall_cnt;
    assign perf_flushes      = r_flush_cnt;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule
